// File: rtl/wallace_dot_sequencer.sv
// Dot-product sequencer around an external combinational 8x8 multiplier.
// Operand pairs are registered onto mul_a/mul_b. Each product is added to
// the accumulator one edge after its pair is accepted.
module wallace_dot_sequencer #(
  parameter int LEN_W = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             in_ready,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  state_t           state, state_nx;
  pair_t            opq;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             pv;    // opq holds a product that has not been added yet
  logic             hs;
  logic             last_beat;
  logic             take;

  assign hs        = in_valid & (state == RUN);
  assign last_beat = hs & (cnt == len_q - LEN_W'(1));
  assign take      = (state == IDLE) & start;
  assign mul_a     = opq.a;
  assign mul_b     = opq.b;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      IDLE:  if (start) state_nx = (len != '0) ? RUN : DONE;
      RUN: begin
        in_ready = 1'b1;
        if (last_beat) state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, beat counting and accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opq   <= '0;
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      pv    <= 1'b0;
    end else begin
      pv <= hs;
      if (hs) begin
        opq <= '{a: in_a, b: in_b};
        cnt <= cnt + LEN_W'(1);
      end
      if (take) begin
        // A job starts from a clean sum. pv is always 0 in IDLE,
        // so no stale product is lost here.
        acc <= '0;
        cnt <= '0;
        if (len != '0) len_q <= len;
      end else if (pv) begin
        acc <= acc + ACC_W'(mul_p);
      end
    end
  end

endmodule

// File: tb/tb_wallace_dot_sequencer.sv
// Scoreboard bench for wallace_dot_sequencer with a behavioural multiplier.
module tb_wallace_dot_sequencer;
  localparam int LEN_W = 4;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic [7:0]       in_a = '0, in_b = '0;
  logic             in_ready;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_p;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ready = 1'b0;

  wallace_dot_sequencer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  assign mul_p = mul_a * mul_b;

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n_acc   = 0;
  int ir_seen = 0;
  logic [7:0] pa [16];
  logic [7:0] pb [16];
  logic [ACC_W-1:0] sb [$];

  // Cumulative handshake and in_ready counters, sampled on pre-edge values.
  always @(posedge clk) begin
    if (in_valid && in_ready) n_acc <= n_acc + 1;
    if (in_ready) ir_seen <= ir_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one job and stops once out_valid is seen, leaving out_ready low.
  task automatic run_job(input int n, input int gap, output logic [ACC_W-1:0] got,
                         output int lat, output logic [7:0] fa, output logic [7:0] fb,
                         output logic ir_drain, output bit to);
    int w;
    to = 0; lat = 0; fa = '0; fb = '0; ir_drain = 1'b0; got = '0;
    @(negedge clk); start = 1'b1; len = n[LEN_W-1:0];
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < n && !to; i++) begin
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) to = 1;
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 0) begin fa = mul_a; fb = mul_b; end
      if (i == n - 1) ir_drain = in_ready;
      else for (int g = 0; g < gap; g++) @(negedge clk);
    end
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) to = 1;
    lat = w;
    got = out_data;
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    vectors++; if ({mul_a, mul_b} !== 16'h0) begin errors++; $display("FAIL reset_mul got %h want 0000", {mul_a, mul_b}); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [ACC_W-1:0] got, exp; int lat, base; logic [7:0] fa, fb; logic ird; bit to;
    pa[0] = 255; pb[0] = 255; pa[1] = 1; pb[1] = 2; pa[2] = 10; pb[2] = 10;
    sb.push_back(20'd65127);
    base = n_acc;
    run_job(3, 0, got, lat, fa, fb, ird, to);
    exp = sb.pop_front();
    vectors++; if (to) begin errors++; $display("FAIL basic_timeout got timeout want out_valid"); end
    vectors++; if (got !== exp) begin errors++; $display("FAIL basic_sum got %0d want %0d", got, exp); end
    vectors++; if (lat !== 1) begin errors++; $display("FAIL basic_latency got %0d want 1", lat); end
    vectors++; if (n_acc - base !== 3) begin errors++; $display("FAIL basic_accepts got %0d want 3", n_acc - base); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b want 1", busy); end
    handshake();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_ovalid_after got %b want 0", out_valid); end
  endtask

  task automatic test_len0();
    logic [ACC_W-1:0] got, exp; int lat, base; logic [7:0] fa, fb; logic ird; bit to;
    sb.push_back('0);
    base = ir_seen;
    run_job(0, 0, got, lat, fa, fb, ird, to);
    exp = sb.pop_front();
    vectors++; if (to) begin errors++; $display("FAIL len0_timeout got timeout want out_valid"); end
    vectors++; if (got !== exp) begin errors++; $display("FAIL len0_sum got %0d want %0d", got, exp); end
    vectors++; if (lat !== 0) begin errors++; $display("FAIL len0_latency got %0d want 0", lat); end
    handshake();
    vectors++; if (ir_seen - base !== 0) begin errors++; $display("FAIL len0_in_ready got %0d pulses want 0", ir_seen - base); end
  endtask

  task automatic test_max();
    logic [ACC_W-1:0] got, exp; int lat; logic [7:0] fa, fb; logic ird; bit to;
    for (int i = 0; i < 15; i++) begin pa[i] = 255; pb[i] = 255; end
    sb.push_back(20'hEE20F);
    run_job(15, 0, got, lat, fa, fb, ird, to);
    exp = sb.pop_front();
    vectors++; if (to) begin errors++; $display("FAIL max_timeout got timeout want out_valid"); end
    vectors++; if (got !== exp) begin errors++; $display("FAIL max_sum got %0d want %0d", got, exp); end
    vectors++; if ({fa, fb} !== 16'hFFFF) begin errors++; $display("FAIL max_mul_first got %h want ffff", {fa, fb}); end
    handshake();
    vectors++; if ({mul_a, mul_b} !== 16'hFFFF) begin errors++; $display("FAIL max_mul_hold got %h want ffff", {mul_a, mul_b}); end
  endtask

  task automatic test_gaps();
    logic [ACC_W-1:0] got, exp; int lat, base; logic [7:0] fa, fb; logic ird; bit to;
    pa[0] = 3; pb[0] = 4; pa[1] = 5; pb[1] = 6; pa[2] = 7; pb[2] = 8; pa[3] = 9; pb[3] = 10;
    sb.push_back(20'd188);
    base = n_acc;
    run_job(4, 2, got, lat, fa, fb, ird, to);
    exp = sb.pop_front();
    vectors++; if (to) begin errors++; $display("FAIL gaps_timeout got timeout want out_valid"); end
    vectors++; if (got !== exp) begin errors++; $display("FAIL gaps_sum got %0d want %0d", got, exp); end
    vectors++; if (n_acc - base !== 4) begin errors++; $display("FAIL gaps_accepts got %0d want 4", n_acc - base); end
    vectors++; if (ird !== 1'b0) begin errors++; $display("FAIL gaps_drain_ready got %b want 0", ird); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] got, exp; int lat, nbad, base; logic [7:0] fa, fb; logic ird; bit to;
    pa[0] = 4; pb[0] = 5; pa[1] = 6; pb[1] = 7;
    sb.push_back(20'd62);
    run_job(2, 0, got, lat, fa, fb, ird, to);
    exp = sb.pop_front();
    vectors++; if (to || got !== exp) begin errors++; $display("FAIL bp_sum got %0d want %0d (timeout=%0d)", got, exp, to); end
    nbad = 0;
    base = ir_seen;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_data !== exp || busy !== 1'b1 || out_valid !== 1'b1) nbad++;
      start = (k == 2); len = 4'd2;
    end
    start = 1'b0;
    vectors++; if (nbad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", nbad); end
    handshake();
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b ovalid=%b want 0/0", busy, out_valid); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored got busy=%b want 0", busy); end
    vectors++; if (ir_seen - base !== 0) begin errors++; $display("FAIL bp_no_run got %0d in_ready cycles want 0", ir_seen - base); end
  endtask

  task automatic test_abort();
    logic [ACC_W-1:0] got, exp; int lat; logic [7:0] fa, fb; logic ird; bit to;
    @(negedge clk); start = 1'b1; len = 4'd5;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100;
    @(negedge clk); in_a = 8'd50; in_b = 8'd60;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_ctrl got busy=%b in_ready=%b want 0/0", busy, in_ready); end
    vectors++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL abort_out got valid=%b data=%0d want 0/0", out_valid, out_data); end
    vectors++; if ({mul_a, mul_b} !== 16'h0) begin errors++; $display("FAIL abort_mul got %h want 0000", {mul_a, mul_b}); end
    @(negedge clk); rst = 1'b0;
    pa[0] = 2; pb[0] = 3;
    sb.push_back(20'd6);
    run_job(1, 0, got, lat, fa, fb, ird, to);
    exp = sb.pop_front();
    vectors++; if (to) begin errors++; $display("FAIL abort_timeout got timeout want out_valid"); end
    vectors++; if (got !== exp) begin errors++; $display("FAIL abort_sum got %0d want %0d", got, exp); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_max();
    test_gaps();
    test_backpressure();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/wallace_dot_sequencer.md
Name: wallace_dot_sequencer

Overview:
- Sequences the shared combinational 8x8 Wallace multiplier to compute one unsigned dot product, sum(a_i*b_i), i = 0..len-1, for one matrix-multiply output element.
- Accepts operand pairs on a valid/ready stream and registers them onto the multiplier inputs.
- Accumulates the 16-bit products into a widened accumulator.
- Presents the result on a valid/ready output.
- The multiplier instance sits outside this block, connected through the mul_* ports.

Parameters:
LEN_W, 4, width of the len input; maximum vector length is 2^LEN_W-1.
ACC_W, 20, accumulator/result width; must equal 16+LEN_W so that no overflow is possible.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a dot product; sampled only in IDLE.
len  input  LEN_W  number of operand pairs; sampled together with start.
busy  output  1  high whenever state != IDLE.
in_valid  input  1  operand pair valid.
in_a  input  8  unsigned operand a.
in_b  input  8  unsigned operand b.
in_ready  output  1  block accepts a pair this cycle.
mul_a  output  8  registered operand driven to multiplier input a1.
mul_b  output  8  registered operand driven to multiplier input b1.
mul_p  input  16  multiplier result; combinational function of mul_a/mul_b.
out_valid  output  1  result valid.
out_data  output  ACC_W  dot-product result.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, beat counter=0, len register=0, product-valid flag pv=0, mul_a=0, mul_b=0. Outputs busy=0, in_ready=0, out_valid=0, out_data=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1, len>0: latch len, clear acc and counter, go to RUN.
  - start=1, len=0: clear acc, go directly to DONE; result is 0.
  - start=0: stay in IDLE.
- RUN:
  - in_ready=1 (combinational from state only).
  - Handshake (in_valid & in_ready) on an edge: mul_a<=in_a, mul_b<=in_b, pv<=1, counter increments.
  - No handshake: pv<=0.
  - Gaps in in_valid are allowed; they only stretch RUN.
  - When the handshake accepts beat number len (counter == len-1 at that edge), go to DRAIN.
- Accumulation, any state: on every edge with pv=1, acc <= acc + zero-extend(mul_p). The product of a beat accepted at edge t is therefore added at edge t+1.
- DRAIN:
  - in_ready=0.
  - The last product is accumulated on this edge; go to DONE.
- DONE:
  - out_valid=1, out_data=acc; both held stable while out_ready=0.
  - On an edge with out_valid & out_ready: go to IDLE and clear out_valid.
- Latency: out_valid rises 2 edges after the edge that accepts the last beat. Minimum job is len+3 cycles from start.
- out_data: equals acc in DONE, and 0 in all other states.
- mul_a/mul_b: hold their last value outside RUN handshakes.
- start while busy: ignored, with no effect on len, acc or counter.
- Arithmetic: unsigned only. Maximum sum (2^LEN_W-1)*65025 fits ACC_W, so no wrap or saturation logic is needed.
- in_valid outside RUN: ignored; in_ready is 0 there, so no pair is lost or duplicated.
- Reset asserted mid-job (any state): immediately returns to IDLE with all reset values. The partial sum is discarded and no out_valid pulse occurs.
- Single outstanding job: no new start is taken until the result handshake completes.

Test Plan:
- start, len=3; pairs (255,255),(1,2),(10,10) with in_valid held high -> out_data=65127. out_valid rises 2 edges after the third accept; busy falls after the out_ready handshake.
- start, len=0 -> DONE next edge, out_valid=1, out_data=0. No in_ready pulse at any time.
- start, len=15; all pairs (255,255) -> out_data=975375 (0xEE20F), no overflow. mul_a/mul_b equal 255 after the first accept.
- len=4, pairs (3,4),(5,6),(7,8),(9,10) with in_valid low 2 cycles between each pair -> out_data=188. Exactly 4 accepts; in_ready=0 in DRAIN.
- In DONE, hold out_ready=0 for 5 cycles and pulse start with len=2 -> out_data stable, start ignored, busy stays 1. Raise out_ready -> one handshake, then IDLE.
- len=5; assert rst after the 2nd accept -> all outputs zero immediately. A new start with len=1 and pair (2,3) -> out_data=6, with no residue from the aborted job.
